// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller for the 5-stage RV32 pipeline
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   id_rs*_addr_i/used_i    source operands of the instruction in ID
//   ex_load_i, ex_we_i,
//   ex_waddr_i              EX instruction load flag, write enable, destination
//   ex_mc_i, mc_done_i      multi-cycle EX op request and its completion pulse
//   mc_start_o, mc_err_o    start pulse to the multi-cycle unit, timeout abort pulse
//   ex_branch_taken_i,
//   ex_branch_target_i      taken branch/jump resolved in EX and its target
//   mem_busy_i              data memory wait
//   stall_o[3:0]            hold PC, IF/ID, ID/EX, EX/MEM
//   flush_o[2:0]            bubble IF/ID, ID/EX, EX/MEM
//   pc_redirect_o,
//   pc_target_o             load PC with pc_target_o
//   busy_o                  waiting on the multi-cycle unit
//   stall_cnt_o             saturating count of cycles with the PC held
module pipe_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic             ex_load_i,
    input  logic             ex_we_i,
    input  logic [4:0]       ex_waddr_i,
    input  logic             ex_mc_i,
    input  logic             mc_done_i,
    input  logic             ex_branch_taken_i,
    input  logic [31:0]      ex_branch_target_i,
    input  logic             mem_busy_i,
    output logic [3:0]       stall_o,
    output logic [2:0]       flush_o,
    output logic             pc_redirect_o,
    output logic [31:0]      pc_target_o,
    output logic             mc_start_o,
    output logic             mc_err_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MC_WAIT = 1'b1;
    localparam int TW = $clog2(MC_TIMEOUT + 1);

    logic [0:0]    state, state_nx;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic          hazard;

    assign hazard = ex_load_i & ex_we_i & (ex_waddr_i != 5'd0) &
                    ((id_rs1_used_i & (id_rs1_addr_i == ex_waddr_i)) |
                     (id_rs2_used_i & (id_rs2_addr_i == ex_waddr_i)));

    // Outputs are gated by rst_n so they drop to 0 as soon as reset asserts.
    always_comb begin
        stall_o       = 4'b0000;
        flush_o       = 3'b000;
        pc_redirect_o = 1'b0;
        mc_start_o    = 1'b0;
        mc_err_o      = 1'b0;
        state_nx      = state;
        tcnt_nx       = tcnt;
        if (!rst_n) begin
            state_nx = RUN;
        end else if (mem_busy_i) begin
            stall_o = 4'b1111;
        end else if (state == MC_WAIT) begin
            if (mc_done_i) begin
                state_nx = RUN;
            end else begin
                stall_o = 4'b0111;
                flush_o = 3'b100;
                tcnt_nx = tcnt + 1'b1;
                if (tcnt == TW'(MC_TIMEOUT - 1)) begin
                    mc_err_o = 1'b1;
                    state_nx = RUN;
                end
            end
        end else if (ex_mc_i) begin
            mc_start_o = 1'b1;
            stall_o    = 4'b0111;
            flush_o    = 3'b100;
            state_nx   = MC_WAIT;
            tcnt_nx    = '0;
        end else if (ex_branch_taken_i) begin
            pc_redirect_o = 1'b1;
            flush_o       = 3'b011;
        end else if (hazard) begin
            stall_o = 4'b0011;
            flush_o = 3'b010;
        end
    end

    assign pc_target_o = pc_redirect_o ? ex_branch_target_i : 32'd0;
    assign busy_o      = rst_n & (state == MC_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            tcnt        <= '0;
            stall_cnt_o <= '0;
        end else begin
            state <= state_nx;
            tcnt  <= tcnt_nx;
            if (stall_o[0] && stall_cnt_o != {CNT_W{1'b1}})
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a behavioural model
module tb_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, waddr;
    logic        rs1_used, rs2_used, ex_load, ex_we, ex_mc, mc_done, br_taken, mem_busy;
    logic [31:0] br_target;
    logic [3:0]  stall, stall3;
    logic [2:0]  flush, flush3;
    logic        redirect, redirect3, start, start3, err, err3, busy, busy3;
    logic [31:0] target, target3;
    logic [31:0] cnt;
    logic [2:0]  cnt3;

    int tests = 0;
    int fails = 0;

    // model state: waiting on the divider, cycles waited so far, stall cycles seen
    bit in_wait;
    int waited;
    int stall_cycles;

    logic [3:0]  e_stall;
    logic [2:0]  e_flush;
    logic        e_redirect, e_start, e_err, e_busy;
    logic [31:0] e_target;

    always #5 clk = ~clk;

    pipe_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
        .ex_load_i(ex_load), .ex_we_i(ex_we), .ex_waddr_i(waddr),
        .ex_mc_i(ex_mc), .mc_done_i(mc_done),
        .ex_branch_taken_i(br_taken), .ex_branch_target_i(br_target),
        .mem_busy_i(mem_busy),
        .stall_o(stall), .flush_o(flush), .pc_redirect_o(redirect), .pc_target_o(target),
        .mc_start_o(start), .mc_err_o(err), .busy_o(busy), .stall_cnt_o(cnt)
    );

    // narrow counter instance to reach saturation
    pipe_ctrl #(.MC_TIMEOUT(64), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
        .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
        .ex_load_i(ex_load), .ex_we_i(ex_we), .ex_waddr_i(waddr),
        .ex_mc_i(ex_mc), .mc_done_i(mc_done),
        .ex_branch_taken_i(br_taken), .ex_branch_target_i(br_target),
        .mem_busy_i(mem_busy),
        .stall_o(stall3), .flush_o(flush3), .pc_redirect_o(redirect3), .pc_target_o(target3),
        .mc_start_o(start3), .mc_err_o(err3), .busy_o(busy3), .stall_cnt_o(cnt3)
    );

    task automatic clr();
        rs1 = 0; rs2 = 0; waddr = 0; rs1_used = 0; rs2_used = 0; ex_load = 0; ex_we = 0;
        ex_mc = 0; mc_done = 0; br_taken = 0; mem_busy = 0; br_target = 0;
    endtask

    task automatic predict();
        bit use_hit;
        use_hit = ex_load && ex_we && waddr != 0 &&
                  ((rs1_used && rs1 == waddr) || (rs2_used && rs2 == waddr));
        e_stall = 0; e_flush = 0; e_redirect = 0; e_start = 0; e_err = 0; e_target = 0;
        e_busy = rst_n && in_wait;
        if (!rst_n) begin
        end else if (mem_busy) e_stall = 4'b1111;
        else if (in_wait) begin
            if (!mc_done) begin
                e_stall = 4'b0111;
                e_flush = 3'b100;
                e_err = (waited == 63);
            end
        end else if (ex_mc) begin
            e_start = 1; e_stall = 4'b0111; e_flush = 3'b100;
        end else if (br_taken) begin
            e_redirect = 1; e_flush = 3'b011; e_target = br_target;
        end else if (use_hit) begin
            e_stall = 4'b0011; e_flush = 3'b010;
        end
    endtask

    task automatic step(input string tag);
        #1;
        if (!rst_n) begin in_wait = 0; waited = 0; stall_cycles = 0; end
        predict();
        tests++; assert (stall === e_stall) else begin fails++; $error("FAIL %s stall_o got %b exp %b", tag, stall, e_stall); end
        tests++; assert (flush === e_flush) else begin fails++; $error("FAIL %s flush_o got %b exp %b", tag, flush, e_flush); end
        tests++; assert (redirect === e_redirect) else begin fails++; $error("FAIL %s pc_redirect_o got %b exp %b", tag, redirect, e_redirect); end
        tests++; assert (target === e_target) else begin fails++; $error("FAIL %s pc_target_o got %h exp %h", tag, target, e_target); end
        tests++; assert (start === e_start) else begin fails++; $error("FAIL %s mc_start_o got %b exp %b", tag, start, e_start); end
        tests++; assert (err === e_err) else begin fails++; $error("FAIL %s mc_err_o got %b exp %b", tag, err, e_err); end
        tests++; assert (busy === e_busy) else begin fails++; $error("FAIL %s busy_o got %b exp %b", tag, busy, e_busy); end
        tests++; assert (cnt === 32'(stall_cycles)) else begin fails++; $error("FAIL %s stall_cnt_o got %0d exp %0d", tag, cnt, stall_cycles); end
        tests++; assert (cnt3 === 3'(stall_cycles > 7 ? 7 : stall_cycles)) else begin fails++; $error("FAIL %s sat stall_cnt_o got %0d exp %0d", tag, cnt3, stall_cycles > 7 ? 7 : stall_cycles); end
        @(posedge clk);
        if (rst_n) begin
            if (e_stall[0]) stall_cycles++;
            if (mem_busy) begin
            end else if (in_wait) begin
                if (mc_done || e_err) in_wait = 0;
                else waited++;
            end else if (ex_mc) begin
                in_wait = 1; waited = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        clr();
        rst_n = 0;
        in_wait = 0; waited = 0; stall_cycles = 0;
        @(negedge clk);
        step("reset");
        rst_n = 1;
        step("idle");

        // load-use on rs1, then hazard gone
        ex_load = 1; ex_we = 1; waddr = 5; rs1 = 5; rs1_used = 1; rs2 = 1; rs2_used = 1;
        step("loaduse");
        clr();
        step("loaduse_after");

        // x0 destination and unused operand never stall
        ex_load = 1; ex_we = 1; waddr = 0; rs1 = 0; rs1_used = 1;
        step("x0_dest");
        clr();
        ex_load = 1; ex_we = 1; waddr = 5; rs2 = 5; rs2_used = 0;
        step("rs2_unused");
        clr();

        // branch overrides a coincident load-use
        br_taken = 1; br_target = 32'h0000_0100;
        ex_load = 1; ex_we = 1; waddr = 7; rs2 = 7; rs2_used = 1;
        step("branch_hazard");
        clr();

        // divider: start, 32 waiting cycles, done
        ex_mc = 1;
        step("div_start");
        for (int i = 0; i < 32; i++) step("div_wait");
        mc_done = 1;
        step("div_done");
        clr();
        step("div_after");
        mc_done = 1;
        step("done_in_run");
        clr();

        // timeout with no done, then done coincident with the final wait cycle
        ex_mc = 1;
        step("to_start");
        for (int i = 0; i < 64; i++) step("to_wait");
        ex_mc = 0;
        step("to_after");
        ex_mc = 1;
        step("to2_start");
        for (int i = 0; i < 63; i++) step("to2_wait");
        mc_done = 1;
        step("to2_done_at_limit");
        clr();
        step("to2_after");

        // mem_busy freezes MC_WAIT, then asynchronous reset mid-wait
        ex_mc = 1;
        step("mb_start");
        for (int i = 0; i < 5; i++) step("mb_wait");
        mem_busy = 1;
        for (int i = 0; i < 3; i++) step("mb_busy");
        mem_busy = 0;
        step("mb_resume");
        mem_busy = 1;
        #2 rst_n = 0;
        step("async_reset");
        rst_n = 1; mem_busy = 0;
        step("post_reset");
        clr();
        step("post_reset_idle");

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            mem_busy  = ($urandom_range(7) == 0);
            ex_mc     = ($urandom_range(15) == 0);
            mc_done   = ($urandom_range(7) == 0);
            br_taken  = ($urandom_range(3) == 0);
            br_target = $urandom;
            ex_load   = $urandom_range(1);
            ex_we     = ($urandom_range(3) != 0);
            waddr     = 5'($urandom_range(7));
            rs1       = 5'($urandom_range(7));
            rs2       = 5'($urandom_range(7));
            rs1_used  = $urandom_range(1);
            rs2_used  = $urandom_range(1);
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
